// File: rtl/cruise_pkg.sv
// Shared types, default constants and saturating helpers for the cruise set-point controller.
package cruise_pkg;

  localparam int unsigned SPEED_W = 8;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } cruise_state_t;

  localparam speed_t DEF_MIN_SET = 8'd30;
  localparam speed_t DEF_MAX_SET = 8'd200;
  localparam speed_t DEF_STEP    = 8'd5;

  // Bit positions of the driver buttons inside the edge-detector vector.
  localparam int unsigned BTN_SET    = 0;
  localparam int unsigned BTN_RESUME = 1;
  localparam int unsigned BTN_CANCEL = 2;
  localparam int unsigned BTN_INC    = 3;
  localparam int unsigned BTN_DEC    = 4;
  localparam int unsigned BTN_N      = 5;

  function automatic speed_t sat_inc(input speed_t cur, input speed_t step,
                                     input speed_t max_v);
    logic [SPEED_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum > {1'b0, max_v}) ? max_v : sum[SPEED_W-1:0];
  endfunction

  function automatic speed_t sat_dec(input speed_t cur, input speed_t step,
                                     input speed_t min_v);
    logic [SPEED_W:0] floor_v;
    floor_v = {1'b0, min_v} + {1'b0, step};
    return ({1'b0, cur} < floor_v) ? min_v : cur - step;
  endfunction

  function automatic speed_t clamp(input speed_t v, input speed_t lo, input speed_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Per-bit rising-edge detector: a bit fires when sampled high after being sampled low.
module btn_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= btn;
    end
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/cruise_setpoint_ctrl.sv
// Cruise set-point sequencer: OFF/ARMED/ACTIVE FSM, saturating set-speed, ramped speed_limit.
// Optional CRUISE_ROAD_CLAMP_EN limits the ramp target to road_limit.
module cruise_setpoint_ctrl
  import cruise_pkg::*;
#(
  parameter speed_t      MIN_SET  = DEF_MIN_SET,
  parameter speed_t      MAX_SET  = DEF_MAX_SET,
  parameter speed_t      STEP     = DEF_STEP,
  parameter int unsigned RAMP_DIV = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_btn,
  input  logic               resume_btn,
  input  logic               cancel_btn,
  input  logic               inc_btn,
  input  logic               dec_btn,
  input  logic               brake,
  input  logic [SPEED_W-1:0] car_speed,
  input  logic [SPEED_W-1:0] road_limit,
  output logic [SPEED_W-1:0] speed_limit,
  output logic [SPEED_W-1:0] set_speed,
  output logic               cruise_active,
  output logic               cruise_armed
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_DIV - 1);

  cruise_state_t    state;
  logic [CNT_W-1:0] ramp_cnt;
  logic [BTN_N-1:0] btn_vec;
  logic [BTN_N-1:0] rise;

  logic   ev_set, ev_resume, ev_cancel, ev_inc, ev_dec;
  logic   in_range, set_ok, stop;
  speed_t ramp_target;

  assign btn_vec[BTN_SET]    = set_btn;
  assign btn_vec[BTN_RESUME] = resume_btn;
  assign btn_vec[BTN_CANCEL] = cancel_btn;
  assign btn_vec[BTN_INC]    = inc_btn;
  assign btn_vec[BTN_DEC]    = dec_btn;

  btn_edge #(
    .W(BTN_N)
  ) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_vec),
    .rise (rise)
  );

  assign ev_set    = rise[BTN_SET];
  assign ev_resume = rise[BTN_RESUME];
  assign ev_cancel = rise[BTN_CANCEL];
  assign ev_inc    = rise[BTN_INC];
  assign ev_dec    = rise[BTN_DEC];

  assign in_range = (car_speed >= MIN_SET) && (car_speed <= MAX_SET);
  assign set_ok   = ev_set && in_range;
  assign stop     = brake || ev_cancel;

`ifdef CRUISE_ROAD_CLAMP_EN
  always_comb begin
    ramp_target = set_speed;
    if (road_limit < set_speed) ramp_target = road_limit;
  end
`else
  logic unused_road_limit;
  assign unused_road_limit = ^road_limit;

  always_comb begin
    ramp_target = set_speed;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OFF;
      set_speed     <= '0;
      speed_limit   <= '0;
      ramp_cnt      <= '0;
      cruise_active <= 1'b0;
      cruise_armed  <= 1'b0;
    end else begin
      unique case (state)
        ST_OFF: begin
          // brake/cancel outrank set even here, so they swallow a coincident set
          if (!stop && set_ok) begin
            state         <= ST_ACTIVE;
            set_speed     <= car_speed;
            speed_limit   <= car_speed;
            ramp_cnt      <= '0;
            cruise_active <= 1'b1;
            cruise_armed  <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (ev_cancel) begin
            state         <= ST_OFF;
            set_speed     <= '0;
            speed_limit   <= '0;
            ramp_cnt      <= '0;
            cruise_active <= 1'b0;
            cruise_armed  <= 1'b0;
          end else if (brake) begin
            state <= ST_ARMED;
          end else if (set_ok) begin
            state         <= ST_ACTIVE;
            set_speed     <= car_speed;
            speed_limit   <= car_speed;
            ramp_cnt      <= '0;
            cruise_active <= 1'b1;
            cruise_armed  <= 1'b0;
          end else if (ev_resume) begin
            state         <= ST_ACTIVE;
            speed_limit   <= clamp(car_speed, MIN_SET, MAX_SET);
            ramp_cnt      <= '0;
            cruise_active <= 1'b1;
            cruise_armed  <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (stop) begin
            state         <= ST_ARMED;
            speed_limit   <= '0;
            ramp_cnt      <= '0;
            cruise_active <= 1'b0;
            cruise_armed  <= 1'b1;
          end else if (set_ok) begin
            set_speed   <= car_speed;
            speed_limit <= car_speed;
            ramp_cnt    <= '0;
          end else begin
            // resume outranks inc/dec, so it blocks them while already active
            if (!ev_resume) begin
              if (ev_inc && !ev_dec) begin
                set_speed <= sat_inc(set_speed, STEP, MAX_SET);
              end else if (ev_dec && !ev_inc) begin
                set_speed <= sat_dec(set_speed, STEP, MIN_SET);
              end
            end
            // the ramp keeps running through target changes; new target is seen at terminal count
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt <= '0;
              if (speed_limit < ramp_target) begin
                speed_limit <= speed_limit + 1'b1;
              end else if (speed_limit > ramp_target) begin
                speed_limit <= speed_limit - 1'b1;
              end
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end
        end

        default: begin
          state         <= ST_OFF;
          set_speed     <= '0;
          speed_limit   <= '0;
          ramp_cnt      <= '0;
          cruise_active <= 1'b0;
          cruise_armed  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cruise_setpoint_ctrl.sv
// Directed self-checking bench for cruise_setpoint_ctrl (default parameters).
module tb_cruise_setpoint_ctrl;

  localparam logic [4:0] B_SET    = 5'b00001;
  localparam logic [4:0] B_RESUME = 5'b00010;
  localparam logic [4:0] B_CANCEL = 5'b00100;
  localparam logic [4:0] B_INC    = 5'b01000;
  localparam logic [4:0] B_DEC    = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       brake;
  logic [7:0] car;
  logic [7:0] road;
  logic [7:0] speed_limit;
  logic [7:0] set_speed;
  logic       cruise_active;
  logic       cruise_armed;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cruise_setpoint_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .set_btn       (btn[0]),
    .resume_btn    (btn[1]),
    .cancel_btn    (btn[2]),
    .inc_btn       (btn[3]),
    .dec_btn       (btn[4]),
    .brake         (brake),
    .car_speed     (car),
    .road_limit    (road),
    .speed_limit   (speed_limit),
    .set_speed     (set_speed),
    .cruise_active (cruise_active),
    .cruise_armed  (cruise_armed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int act, input int arm,
                           input int ss, input int sl);
    check({tag, ".active"}, 32'(cruise_active), act);
    check({tag, ".armed"},  32'(cruise_armed),  arm);
    check({tag, ".set"},    32'(set_speed),     ss);
    check({tag, ".limit"},  32'(speed_limit),   sl);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one rising edge on the selected buttons, then a low cycle so the next press is a new edge
  task automatic press(input logic [4:0] mask);
    btn = mask;
    tick(1);
    btn = '0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; btn = '0; brake = 1'b0; car = '0; road = 8'd255;
    #1;
    check_out("reset", 0, 0, 0, 0);
    tick(2);
    rst = 1'b0;

    car = 8'd20; press(B_SET);
    check_out("set_out_of_range", 0, 0, 0, 0);
    car = 8'd60; press(B_SET);
    check_out("set60", 1, 0, 60, 60);

    press(B_INC); press(B_INC); press(B_INC);
    check("inc3.set", 32'(set_speed), 75);
    check("inc3.limit", 32'(speed_limit), 60);
    tick(232);
    check("ramp_239", 32'(speed_limit), 74);
    tick(1);
    check("ramp_240", 32'(speed_limit), 75);
    tick(40);
    check("ramp_hold", 32'(speed_limit), 75);

    car = 8'd201; press(B_SET);
    check("set_201_ignored", 32'(set_speed), 75);

    car = 8'd198; press(B_SET);
    check_out("set198", 1, 0, 198, 198);
    press(B_INC);
    check("inc_sat", 32'(set_speed), 200);
    press(B_INC);
    check("inc_at_max", 32'(set_speed), 200);

    car = 8'd32; press(B_SET);
    press(B_INC | B_DEC);
    check("inc_dec_same", 32'(set_speed), 32);
    press(B_DEC);
    check("dec_sat", 32'(set_speed), 30);
    press(B_DEC);
    check("dec_at_min", 32'(set_speed), 30);

    car = 8'd60; press(B_SET);
    check_out("recapture60", 1, 0, 60, 60);
    brake = 1'b1; tick(1);
    check_out("brake", 0, 1, 60, 0);
    press(B_RESUME);
    check_out("resume_braking", 0, 1, 60, 0);
    brake = 1'b0; tick(1);
    car = 8'd50; press(B_RESUME);
    check_out("resume50", 1, 0, 60, 50);
    tick(14);
    check("resume_ramp_15", 32'(speed_limit), 50);
    tick(1);
    check("resume_ramp_16", 32'(speed_limit), 51);
    tick(16);
    check("resume_ramp_32", 32'(speed_limit), 52);

    press(B_CANCEL);
    check_out("cancel_active", 0, 1, 60, 0);
    car = 8'd10; press(B_RESUME);
    check_out("resume_clamp_low", 1, 0, 60, 30);
    press(B_CANCEL); press(B_CANCEL);
    check_out("cancel_armed", 0, 0, 0, 0);

    car = 8'd60; press(B_SET);
    car = 8'd90; press(B_CANCEL | B_SET);
    check_out("cancel_beats_set", 0, 1, 60, 0);

    press(B_CANCEL);
    car = 8'd70; btn = B_SET; tick(1);
    car = 8'd90; tick(9);
    check_out("set_held", 1, 0, 70, 70);
    btn = '0; tick(1);

    car = 8'd80; road = 8'd70; press(B_SET);
    check("road.start", 32'(speed_limit), 80);
    tick(200);
    check("road.set", 32'(set_speed), 80);
`ifdef CRUISE_ROAD_CLAMP_EN
    check("road.settle", 32'(speed_limit), 70);
`else
    check("road.settle", 32'(speed_limit), 80);
`endif
    road = 8'd255;

    car = 8'd40; press(B_SET); press(B_INC); press(B_INC);
    tick(20);
    check("midramp", 32'(speed_limit), 41);
    rst = 1'b1; #2;
    check_out("async_reset", 0, 0, 0, 0);

    btn = B_SET; car = 8'd60;
    tick(1);
    check_out("held_in_reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);
    check_out("edge_after_reset", 1, 0, 60, 60);
    btn = '0; tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
